// File: rtl/sync_test_sequencer.sv
// sync_test_sequencer: clk-domain sequencer that drives the synchronizer test datapath; define SYNC_SEQ_LFSR_EN for an LFSR test pattern
module sync_test_sequencer #(
    parameter int N      = 8,
    parameter int ITER_W = 8,
    parameter int TO_W   = 8,
    parameter int SETTLE = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ITER_W-1:0] iterations,
    input  logic [2:0]        mode_in,
    input  logic              ack_tgl_b,
    input  logic [N-1:0]      data_back,
    output logic [N-1:0]      tx_data,
    output logic              tx_en,
    output logic              tx_pulse,
    output logic [2:0]        sel,
    output logic              busy,
    output logic              done,
    output logic [7:0]        err_cnt,
    output logic [ITER_W-1:0] pass_cnt,
    output logic              timeout
);
    typedef enum logic [2:0] {IDLE, LOAD, FIRE, WAIT_ACK, CHECK, NEXT, DONE} state_t;
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    state_t state, state_nx;
    logic [2:0] ack_sync;
    logic start_q, start_evt, ack_evt, to_hit, idle;
    logic [SW-1:0] settle_cnt;
    logic [TO_W-1:0] to_cnt;
    logic [ITER_W-1:0] iter_left;
    logic [N-1:0] pattern, pattern_nx;
    logic [7:0] err_inc;
`ifdef SYNC_SEQ_LFSR_EN
    if (N != 8) begin : g_n_check
        $error("SYNC_SEQ_LFSR_EN requires N == 8");
    end
    assign pattern_nx = {1'b0, pattern[N-1:1]} ^ (pattern[0] ? N'(8'hB8) : '0);
`else
    assign pattern_nx = pattern + N'(1);
`endif
    assign ack_evt   = ack_sync[1] ^ ack_sync[2];
    assign start_evt = start & ~start_q;
    assign to_hit    = to_cnt == TO_W'((1 << TO_W) - 2);
    assign err_inc   = err_cnt == 8'hFF ? err_cnt : err_cnt + 8'd1;
    assign idle      = state == IDLE || state == DONE;
    always_comb begin
        state_nx = state;
        busy     = !idle;
        tx_en    = !idle;
        tx_pulse = state == FIRE;
        if (abort)
            state_nx = IDLE;
        else
            case (state)
                IDLE, DONE: state_nx = start_evt ? (iterations == '0 ? DONE : LOAD) : state;
                LOAD:       state_nx = settle_cnt == SW'(SETTLE - 1) ? FIRE : LOAD;
                FIRE:       state_nx = WAIT_ACK;
                WAIT_ACK:   state_nx = ack_evt ? CHECK : (to_hit ? NEXT : WAIT_ACK);
                CHECK:      state_nx = NEXT;
                NEXT:       state_nx = iter_left == ITER_W'(1) ? DONE : LOAD;
                default:    state_nx = IDLE;
            endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            ack_sync   <= '0;
            start_q    <= 1'b0;
            settle_cnt <= '0;
            to_cnt     <= '0;
            iter_left  <= '0;
            pattern    <= N'(1);
            tx_data    <= '0;
            sel        <= '0;
            done       <= 1'b0;
            err_cnt    <= '0;
            pass_cnt   <= '0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_nx;
            ack_sync   <= {ack_sync[1:0], ack_tgl_b};
            start_q    <= start;
            settle_cnt <= state == LOAD ? settle_cnt + SW'(1) : '0;
            to_cnt     <= state == WAIT_ACK ? to_cnt + TO_W'(1) : '0;
            done       <= state_nx == DONE;
            if (state_nx == LOAD)
                tx_data <= state == NEXT ? pattern_nx : pattern;
            if (!abort) begin
                if (idle && start_evt) begin
                    sel       <= mode_in;
                    iter_left <= iterations;
                    err_cnt   <= '0;
                    pass_cnt  <= '0;
                    timeout   <= 1'b0;
                end
                if (state == WAIT_ACK && !ack_evt && to_hit) begin
                    timeout <= 1'b1;
                    err_cnt <= err_inc;
                end
                if (state == CHECK) begin
                    if (data_back == pattern)
                        pass_cnt <= pass_cnt + ITER_W'(1);
                    else
                        err_cnt <= err_inc;
                end
                if (state == NEXT) begin
                    pattern   <= pattern_nx;
                    iter_left <= iter_left - ITER_W'(1);
                end
            end
        end
    end
endmodule
